// File: rtl/mul_div_unit_if.sv
// Bundle of the operation request, HI/LO move and result signals between
// the execute stage and the iterative multiply/divide unit.
interface mul_div_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] srcA;
    logic [DATA_W-1:0] srcB;
    logic              wrHI;
    logic              wrLO;
    logic [DATA_W-1:0] wrData;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    // Execute-stage side: issues operations and MTHI/MTLO, reads HI/LO
    modport master (
        output start, op, srcA, srcB, wrHI, wrLO, wrData,
        input  busy, done, HI, LO
    );

    // Unit side
    modport slave (
        input  start, op, srcA, srcB, wrHI, wrLO, wrData,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with dedicated HI/LO registers.
// Operands are reduced to magnitudes when the operation starts, one
// shift-add (multiply) or restoring subtract-shift (divide) step is taken
// per cycle for DATA_W cycles, and the sign fix-up is folded into the
// HI/LO write on the last step so the result is visible during FINISH.
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic           CLK,
    input  logic           Reset,
    mul_div_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    // Magnitude of a possibly signed operand, modulo 2^DATA_W so that the
    // most negative value maps onto itself as an unsigned number.
    function automatic logic [DATA_W-1:0] magnitude(
        input logic signed [DATA_W-1:0] value,
        input logic                     is_signed
    );
        logic [DATA_W-1:0] result;
        if (is_signed && (value < 0)) begin
            result = -value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Conditional two's-complement negation of a DATA_W-bit magnitude.
    function automatic logic [DATA_W-1:0] apply_sign(
        input logic [DATA_W-1:0] mag,
        input logic              negate
    );
        return negate ? -mag : mag;
    endfunction

    // Conditional two's-complement negation of a full-width product.
    function automatic logic [2*DATA_W-1:0] apply_sign_wide(
        input logic [2*DATA_W-1:0] mag,
        input logic                negate
    );
        return negate ? -mag : mag;
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic              is_div;
    logic              neg_main;     // negate product / quotient
    logic              neg_rem;      // negate remainder (dividend sign)
    logic              div_zero;
    logic [DATA_W-1:0] operand_b;    // multiplicand or divisor magnitude
    logic [DATA_W-1:0] hi_acc;       // partial product high half / remainder
    logic [DATA_W-1:0] lo_acc;       // multiplier bits / dividend -> quotient
    logic [DATA_W-1:0] src_a_raw;    // dividend as issued, for divide by zero
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] hi_step;
    logic [DATA_W-1:0] lo_step;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0] hi_final;
    logic [DATA_W-1:0] lo_final;

    logic a_neg;
    logic b_neg;
    logic last_step;

    assign a_neg     = bus.srcA[DATA_W-1];
    assign b_neg     = bus.srcB[DATA_W-1];
    assign last_step = (state == CALC) && (count == '0);

    // One iteration of the active algorithm from the current accumulators
    always_comb begin
        sum_w   = {1'b0, hi_acc} + {1'b0, operand_b};
        shifted = {hi_acc, lo_acc[DATA_W-1]};
        diff    = shifted - {1'b0, operand_b};
        hi_step = hi_acc;
        lo_step = lo_acc;
        if (is_div) begin
            // restoring step: keep the trial difference only if it did not borrow
            hi_step = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
            lo_step = {lo_acc[DATA_W-2:0], ~diff[DATA_W]};
        end else if (lo_acc[0]) begin
            hi_step = sum_w[DATA_W:1];
            lo_step = {sum_w[0], lo_acc[DATA_W-1:1]};
        end else begin
            hi_step = {1'b0, hi_acc[DATA_W-1:1]};
            lo_step = {hi_acc[0], lo_acc[DATA_W-1:1]};
        end
    end

    // Signed result fix-up applied to the output of the last iteration
    always_comb begin
        prod_fix = apply_sign_wide({hi_step, lo_step}, neg_main);
        hi_final = prod_fix[2*DATA_W-1:DATA_W];
        lo_final = prod_fix[DATA_W-1:0];
        if (is_div) begin
            if (div_zero) begin
                hi_final = src_a_raw;
                lo_final = '1;
            end else begin
                hi_final = apply_sign(hi_step, neg_rem);
                lo_final = apply_sign(lo_step, neg_main);
            end
        end
    end

    // Sequencer and iteration datapath: latch magnitudes, step, finish
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            is_div    <= 1'b0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            operand_b <= '0;
            hi_acc    <= '0;
            lo_acc    <= '0;
            src_a_raw <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= CALC;
                        count     <= CNT_W'(DATA_W - 1);
                        is_div    <= bus.op[1];
                        neg_main  <= bus.op[0] & (a_neg ^ b_neg);
                        neg_rem   <= bus.op[0] & a_neg;
                        div_zero  <= (bus.srcB == '0);
                        operand_b <= magnitude(bus.srcB, bus.op[0]);
                        lo_acc    <= magnitude(bus.srcA, bus.op[0]);
                        hi_acc    <= '0;
                        src_a_raw <= bus.srcA;
                    end
                end
                CALC: begin
                    hi_acc <= hi_step;
                    lo_acc <= lo_step;
                    if (count == '0) begin
                        state <= FINISH;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // HI/LO: result written on the last step, MTHI/MTLO only when idle and not starting
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (last_step) begin
            hi_reg <= hi_final;
            lo_reg <= lo_final;
        end else if ((state == IDLE) && !bus.start) begin
            if (bus.wrHI) begin
                hi_reg <= bus.wrData;
            end
            if (bus.wrLO) begin
                lo_reg <= bus.wrData;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == FINISH);
    assign bus.HI   = hi_reg;
    assign bus.LO   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO pairs are queued when an
// operation is issued and checked by a monitor whenever done is seen.
module tb_mul_div_unit;

    localparam int M_PLAIN   = 0;
    localparam int M_RESTART = 1;
    localparam int M_WRBUSY  = 2;
    localparam int M_ABORT   = 3;
    localparam int M_MTSTART = 4;

    logic CLK;
    logic Reset;

    mul_div_unit_if #(.DATA_W(32)) bus ();

    mul_div_unit #(.DATA_W(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb_v;
        longint q;
        longint r;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        p    = '0;
        case (o)
            2'd0: p = {32'b0, a} * {32'b0, b};
            2'd1: p = 64'(sa * sb_v);
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (o == 2'd2) begin
                    p = {a % b, a / b};
                end else begin
                    q = sa / sb_v;
                    r = sa % sb_v;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'($urandom_range(20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: compare the oldest expected result whenever done is presented
    always @(negedge CLK) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                check("result_hi", {32'b0, bus.HI}, {32'b0, exp[63:32]});
                check("result_lo", {32'b0, bus.LO}, {32'b0, exp[31:0]});
            end
        end
    end

    // Issue one operation; k counts edges after the sampling edge (k=0)
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [31:0] lo_before;
        logic [31:0] hi_before;
        int k;
        int busy_cnt;
        int done_at;
        bit aborted;
        @(negedge CLK);
        lo_before  = bus.LO;
        hi_before  = bus.HI;
        bus.start  = 1'b1;
        bus.op     = o;
        bus.srcA   = a;
        bus.srcB   = b;
        if (mode == M_MTSTART) begin
            bus.wrLO   = 1'b1;
            bus.wrData = 32'hDEAD_BEEF;
        end
        sb.push_back(model(o, a, b));
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        bus.wrLO  = 1'b0;
        if (mode == M_MTSTART) check("mt_with_start_lo", {32'b0, bus.LO}, {32'b0, lo_before});
        k = 0;
        busy_cnt = 0;
        done_at = -1;
        aborted = 1'b0;
        while (bus.busy && k < 100) begin
            busy_cnt++;
            if (bus.done && done_at < 0) done_at = k;
            bus.start = 1'b0;
            bus.wrHI  = 1'b0;
            bus.wrLO  = 1'b0;
            if (mode == M_RESTART && (k == 5 || k == 20)) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom_range(3));
                bus.srcA  = $urandom;
                bus.srcB  = $urandom;
            end
            if (mode == M_WRBUSY && k == 10) begin
                hi_before  = bus.HI;
                lo_before  = bus.LO;
                bus.wrHI   = 1'b1;
                bus.wrLO   = 1'b1;
                bus.wrData = $urandom;
            end
            if (mode == M_WRBUSY && k == 12) begin
                check("wr_busy_hi", {32'b0, bus.HI}, {32'b0, hi_before});
                check("wr_busy_lo", {32'b0, bus.LO}, {32'b0, lo_before});
            end
            if (mode == M_ABORT && k == 10) begin
                #2;
                Reset = 1'b1;
                #1;
                check("abort_busy", {63'b0, bus.busy}, 64'd0);
                check("abort_done", {63'b0, bus.done}, 64'd0);
                check("abort_hi", {32'b0, bus.HI}, 64'd0);
                check("abort_lo", {32'b0, bus.LO}, 64'd0);
                void'(sb.pop_back());
                @(negedge CLK);
                Reset = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
            k++;
        end
        bus.start = 1'b0;
        bus.wrHI  = 1'b0;
        bus.wrLO  = 1'b0;
        if (!aborted) begin
            check("busy_timeout", {63'b0, (k < 100)}, 64'd1);
            check("done_latency", 64'(done_at), 64'd32);
            check("busy_cycles", 64'(busy_cnt), 64'd33);
            check("done_after", {63'b0, bus.done}, 64'd0);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'd0;
        bus.srcA   = '0;
        bus.srcB   = '0;
        bus.wrHI   = 1'b0;
        bus.wrLO   = 1'b0;
        bus.wrData = '0;
        #2;
        check("reset_busy", {63'b0, bus.busy}, 64'd0);
        check("reset_done", {63'b0, bus.done}, 64'd0);
        check("reset_hi", {32'b0, bus.HI}, 64'd0);
        check("reset_lo", {32'b0, bus.LO}, 64'd0);
        @(negedge CLK);
        Reset = 1'b0;

        // directed cases
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, M_PLAIN);
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, M_PLAIN);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, M_PLAIN);
        run_op(2'd2, 32'd100, 32'd0, M_PLAIN);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, M_PLAIN);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd0, M_PLAIN);
        run_op(2'd0, 32'd3, 32'd4, M_RESTART);

        // MTHI / MTLO in idle
        @(negedge CLK);
        bus.wrHI   = 1'b1;
        bus.wrData = 32'h1234;
        @(posedge CLK);
        #1;
        bus.wrHI = 1'b0;
        check("mthi", {32'b0, bus.HI}, 64'h1234);
        @(negedge CLK);
        bus.wrLO   = 1'b1;
        bus.wrData = 32'h5678;
        @(posedge CLK);
        #1;
        bus.wrLO = 1'b0;
        check("mtlo", {32'b0, bus.LO}, 64'h5678);
        check("mtlo_hi_kept", {32'b0, bus.HI}, 64'h1234);

        run_op(2'd0, 32'd3, 32'd4, M_MTSTART);
        run_op(2'd1, $urandom, $urandom, M_WRBUSY);

        // abort a divide with an asynchronous reset, then divide again
        run_op(2'd2, 32'd1000, 32'd7, M_ABORT);
        run_op(2'd2, 32'd9, 32'd4, M_PLAIN);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(3)), pick(), pick(), M_PLAIN);
        end

        repeat (3) @(posedge CLK);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
